// File: rtl/switch_voq_islip_sched_pkg.sv
// Shared switch definitions: default port count, pointer width and the VOQ
// bit-index helper used by the scheduler, crossbar and VOQ buffers.
package switch_voq_islip_sched_pkg;

  localparam int RADIX    = 4;
  localparam int CL_RADIX = $clog2(RADIX);

  // Flat bit position of the VOQ that holds traffic from input i to output o.
  function automatic int voq_idx(input int o, input int i, input int radix = RADIX);
    return o * radix + i;
  endfunction

endpackage

// File: rtl/switch_voq_islip_sched_rr_pick.sv
// Combinational N-wide round-robin picker: first set request at or above ptr,
// wrapping past N-1 back to 0 by explicit compare (N need not be a power of two).
module switch_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    int          c;
    logic [W-1:0] cw;
    c     = 0;
    cw    = '0;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      cw = W'(c);
      if (!valid && req[cw]) begin
        valid     = 1'b1;
        grant[cw] = 1'b1;
        idx       = cw;
      end
    end
  end

endmodule

// File: rtl/switch_voq_islip_sched.sv
// Single-iteration iSLIP scheduler for a RADIX x RADIX VOQ crossbar. Matches
// are registered, held for a whole packet, and released on the tlast beat.
module switch_voq_islip_sched
  import switch_voq_islip_sched_pkg::*;
#(
  parameter int RADIX = switch_voq_islip_sched_pkg::RADIX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [RADIX*RADIX-1:0]   req,
  input  logic [RADIX*RADIX-1:0]   done,
  output logic [RADIX*RADIX-1:0]   match,
  output logic [RADIX-1:0]         in_busy,
  output logic [RADIX-1:0]         out_busy
);

  localparam int CL_RADIX = $clog2(RADIX);

  // All 2-D views below are indexed [first][second] as named: [o][i] or [i][o].
  logic [RADIX-1:0][RADIX-1:0]    elig_oi;
  logic [RADIX-1:0][RADIX-1:0]    match_oi;
  logic [RADIX-1:0][RADIX-1:0]    match_io;
  logic [RADIX-1:0][RADIX-1:0]    gnt_oi;
  logic [RADIX-1:0]               gnt_valid;
  logic [RADIX-1:0][CL_RADIX-1:0] gnt_idx;
  logic [RADIX-1:0][RADIX-1:0]    gnt_io;
  logic [RADIX-1:0][RADIX-1:0]    acc_io;
  logic [RADIX-1:0][RADIX-1:0]    acc_oi;
  logic [RADIX-1:0]               acc_valid;
  logic [RADIX-1:0][CL_RADIX-1:0] acc_idx;
  logic [RADIX-1:0]               out_acc;
  logic [RADIX*RADIX-1:0]         new_match;
  logic [RADIX-1:0][CL_RADIX-1:0] gp;
  logic [RADIX-1:0][CL_RADIX-1:0] ap;

  function automatic logic [CL_RADIX-1:0] ptr_inc(input logic [CL_RADIX-1:0] p);
    return (p == CL_RADIX'(RADIX - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar o = 0; o < RADIX; o++) begin : g_o
    for (genvar i = 0; i < RADIX; i++) begin : g_i
      localparam int K = voq_idx(o, i, RADIX);
      // Only idle pairs compete; done is irrelevant to eligibility.
      assign elig_oi[o][i]  = enable & req[K] & ~in_busy[i] & ~out_busy[o];
      assign match_oi[o][i] = match[K];
      assign match_io[i][o] = match[K];
      assign gnt_io[i][o]   = gnt_valid[o] & gnt_oi[o][i];
      assign acc_oi[o][i]   = acc_io[i][o];
      assign new_match[K]   = acc_io[i][o];
    end
  end

  for (genvar o = 0; o < RADIX; o++) begin : g_grant
    switch_rr_pick #(.N(RADIX), .W(CL_RADIX)) u_pick (
      .req   (elig_oi[o]),
      .ptr   (gp[o]),
      .grant (gnt_oi[o]),
      .valid (gnt_valid[o]),
      .idx   (gnt_idx[o])
    );

    assign out_busy[o] = |match_oi[o];
    assign out_acc[o]  = |acc_oi[o];

    // Grant pointer moves only when its grant was accepted (desynchronisation).
    always_ff @(posedge clk) begin
      if (rst) gp[o] <= '0;
      else if (out_acc[o]) gp[o] <= ptr_inc(gnt_idx[o]);
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(match_oi[o]))
      else $error("output %0d matched to more than one input", o);
  end

  for (genvar i = 0; i < RADIX; i++) begin : g_accept
    switch_rr_pick #(.N(RADIX), .W(CL_RADIX)) u_pick (
      .req   (gnt_io[i]),
      .ptr   (ap[i]),
      .grant (acc_io[i]),
      .valid (acc_valid[i]),
      .idx   (acc_idx[i])
    );

    assign in_busy[i] = |match_io[i];

    always_ff @(posedge clk) begin
      if (rst) ap[i] <= '0;
      else if (acc_valid[i]) ap[i] <= ptr_inc(acc_idx[i]);
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(match_io[i]))
      else $error("input %0d matched to more than one output", i);
  end

  // done only clears bits that are set; new matches land only on idle pairs.
  always_ff @(posedge clk) begin
    if (rst) match <= '0;
    else     match <= (match & ~done) | new_match;
  end

endmodule

// File: tb/tb_switch_voq_islip_sched.sv
// Directed bench for the iSLIP scheduler (RADIX=4): reset, single flow,
// output contention, permutation, pointer desync and boundary cases.
module tb_switch_voq_islip_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] done = '0;
  logic [15:0] match;
  logic [3:0]  in_busy;
  logic [3:0]  out_busy;

  int tests = 0;
  int fails = 0;

  switch_voq_islip_sched dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .match    (match),
    .in_busy  (in_busy),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = '0; enable = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (match !== 16'h0 || in_busy !== 4'h0 || out_busy !== 4'h0) begin
        $display("FAIL reset_idle cycle %0d: match=%h in_busy=%h out_busy=%h, want 0/0/0",
                 c, match, in_busy, out_busy);
        fails++;
      end
      tick();
    end
    tests++;
    if (dut.gp !== 8'h00 || dut.ap !== 8'h00) begin
      $display("FAIL reset_ptrs: gp=%h ap=%h, want 00/00", dut.gp, dut.ap);
      fails++;
    end
  endtask

  task automatic test_single_flow();
    do_reset();
    req = 16'h0200;
    tick();
    tests++;
    if (match !== 16'h0200 || in_busy !== 4'b0010 || out_busy !== 4'b0100) begin
      $display("FAIL single_match: match=%h in=%h out=%h, want 0200/2/4", match, in_busy, out_busy);
      fails++;
    end
    for (int c = 0; c < 4; c++) begin
      req = (c % 2 == 0) ? 16'h0000 : 16'h0200;
      tick();
      tests++;
      if (match !== 16'h0200) begin
        $display("FAIL single_hold cycle %0d: match=%h, want 0200", c, match);
        fails++;
      end
    end
    req = '0; done = 16'h0200;
    tick();
    done = '0;
    tests++;
    if (match !== 16'h0000 || in_busy !== 4'h0 || out_busy !== 4'h0) begin
      $display("FAIL single_release: match=%h in=%h out=%h, want 0/0/0", match, in_busy, out_busy);
      fails++;
    end
    tests++;
    if (dut.gp[2] !== 2'd2 || dut.ap[1] !== 2'd3) begin
      $display("FAIL single_ptrs: gp[2]=%0d ap[1]=%0d, want 2/3", dut.gp[2], dut.ap[1]);
      fails++;
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_m;
    do_reset();
    req = 16'h000F;
    for (int k = 0; k < 5; k++) begin
      exp_m = 16'h0001 << (k % 4);
      tick();
      tests++;
      if (match !== exp_m) begin
        $display("FAIL contention_grant %0d: match=%h, want %h", k, match, exp_m);
        fails++;
      end
      done = exp_m;
      tick();
      done = '0;
      tests++;
      if (match !== 16'h0000) begin
        $display("FAIL contention_gap %0d: match=%h, want 0000", k, match);
        fails++;
      end
    end
    req = '0;
  endtask

  task automatic test_permutation();
    do_reset();
    req = 16'h4218;
    tick();
    tests++;
    if (match !== 16'h4218 || in_busy !== 4'hF || out_busy !== 4'hF) begin
      $display("FAIL permutation: match=%h in=%h out=%h, want 4218/F/F", match, in_busy, out_busy);
      fails++;
    end
    req = '0; done = 16'h4218;
    tick();
    done = '0;
    tests++;
    if (match !== 16'h0000) begin
      $display("FAIL permutation_release: match=%h, want 0000", match);
      fails++;
    end
  endtask

  task automatic test_desync();
    do_reset();
    req = 16'h0033;
    tick();
    tests++;
    if (match !== 16'h0001) begin
      $display("FAIL desync_first: match=%h, want 0001", match);
      fails++;
    end
    tests++;
    if (dut.gp[0] !== 2'd1 || dut.gp[1] !== 2'd0 || dut.ap[0] !== 2'd1) begin
      $display("FAIL desync_ptrs: gp0=%0d gp1=%0d ap0=%0d, want 1/0/1", dut.gp[0], dut.gp[1], dut.ap[0]);
      fails++;
    end
    req = '0; done = 16'h0001;
    tick();
    done = '0;
    req = 16'h0033;
    tick();
    tests++;
    if (match !== 16'h0012 || in_busy !== 4'h3 || out_busy !== 4'h3) begin
      $display("FAIL desync_second: match=%h in=%h out=%h, want 0012/3/3", match, in_busy, out_busy);
      fails++;
    end
    req = '0;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; req = 16'h0001;
    tick(); tick();
    tests++;
    if (match !== 16'h0000) begin
      $display("FAIL enable_off_blocks: match=%h, want 0000", match);
      fails++;
    end
    enable = 1'b1;
    tick();
    tests++;
    if (match !== 16'h0001) begin
      $display("FAIL enable_on_match: match=%h, want 0001", match);
      fails++;
    end
    enable = 1'b0;
    tick();
    tests++;
    if (match !== 16'h0001) begin
      $display("FAIL enable_off_hold: match=%h, want 0001", match);
      fails++;
    end
    done = 16'h0001;
    tick();
    done = '0;
    tick();
    tests++;
    if (match !== 16'h0000) begin
      $display("FAIL enable_off_release: match=%h, want 0000", match);
      fails++;
    end
    enable = 1'b1; req = '0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = 16'h0001;
    tick();
    tests++;
    if (match !== 16'h0001) begin
      $display("FAIL rst_mid_setup: match=%h, want 0001", match);
      fails++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    tests++;
    if (match !== 16'h0000 || in_busy !== 4'h0 || out_busy !== 4'h0) begin
      $display("FAIL rst_mid_drop: match=%h in=%h out=%h, want 0/0/0", match, in_busy, out_busy);
      fails++;
    end
  endtask

  task automatic test_done_unmatched();
    do_reset();
    req = 16'h0001;
    tick();
    req = '0; done = 16'h0002;
    tick();
    done = '0;
    tests++;
    if (match !== 16'h0001 || in_busy !== 4'h1 || out_busy !== 4'h1) begin
      $display("FAIL done_unmatched: match=%h in=%h out=%h, want 0001/1/1", match, in_busy, out_busy);
      fails++;
    end
    req = 16'h0020; done = 16'h0020;
    tick();
    req = '0; done = '0;
    tests++;
    if (match !== 16'h0021) begin
      $display("FAIL done_and_req_idle: match=%h, want 0021", match);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_single_flow();
    test_contention();
    test_permutation();
    test_desync();
    test_enable();
    test_rst_mid();
    test_done_unmatched();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
